// File: rtl/serial_pkg.sv
// Shared definitions for the serial nibble collector: default word width,
// counter sizing helper and the hold-register state encoding.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_shifter.sv
// Serial-to-parallel shift register with its bit position counter.
// 'word' shows the register including the bit accepted this cycle, so the
// parent can capture a finished word on the same edge that 'done' is high.
module bit_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic             bit_in,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam int FIRST_POS = MSB_FIRST ? WIDTH - 1 : 0;

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos;

  always_comb begin
    pos = MSB_FIRST ? (LAST - cnt) : cnt;
    shreg_next = shreg;
    if (accept) begin
      shreg_next[pos] = bit_in;
    end
  end

  // A resync in the same cycle as the last bit wins: no word is produced.
  assign done    = accept && !frame_sync && (cnt == LAST);
  assign word    = shreg_next;
  assign bit_cnt = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (frame_sync) begin
      shreg <= '0;
      cnt   <= '0;
      if (accept) begin
        shreg[FIRST_POS] <= bit_in;
        cnt              <= CNT_W'(1);
      end
    end else if (done) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= shreg_next;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_nibble_collector.sv
// Collects serial bits into WIDTH-bit words and offers each finished word to
// the downstream reduction stage through a one-deep registered hold stage.
module serial_nibble_collector
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] nib_out,
  output logic             nib_valid,
  input  logic             nib_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [7:0]       nib_total
);

  // Handshake: a bit transfers when bit_valid && bit_ready, a word transfers
  // when nib_valid && nib_ready; valid holds its payload stable until ready.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  hold_state_t      state;
  logic             accept;
  logic             handshake;
  logic             done;
  logic [WIDTH-1:0] word;

  assign nib_valid = (state == FULL);
  assign handshake = nib_valid && nib_ready;
  // Only the completing bit can stall: it needs the hold register free.
  assign bit_ready = !((bit_cnt == LAST) && nib_valid && !nib_ready);
  assign accept    = bit_valid && bit_ready;

  bit_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .bit_in     (bit_in),
    .frame_sync (frame_sync),
    .word       (word),
    .done       (done),
    .bit_cnt    (bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      nib_out   <= '0;
      nib_total <= '0;
    end else begin
      if (handshake) begin
        nib_total <= nib_total + 8'd1;
      end
      case (state)
        EMPTY: begin
          if (done) begin
            nib_out <= word;
            state   <= FULL;
          end
        end
        FULL: begin
          if (done) begin
            nib_out <= word;
            state   <= FULL;
          end else if (handshake) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_collector.sv
// Bench for serial_nibble_collector: an LSB-first and an MSB-first instance
// share one stimulus stream and are checked against a bit-list/word-queue model.
module tb_serial_nibble_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       nib_ready = 1'b0;

  logic       bit_ready, m_bit_ready;
  logic [3:0] nib_out, m_nib_out;
  logic       nib_valid, m_nib_valid;
  logic [1:0] bit_cnt, m_bit_cnt;
  logic [7:0] nib_total, m_nib_total;

  int total = 0;
  int bad = 0;

  // Reference model: bits of the word in progress, words awaiting delivery,
  // the last word loaded (what nib_out shows) and the delivered-word count.
  bit         pbits[$];
  logic [3:0] exp_q[$];
  logic [3:0] exp_m_q[$];
  logic [3:0] last_l, last_m;
  int         mtotal;
  logic       obs_ready;

  always #5 clk = ~clk;

  serial_nibble_collector #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .frame_sync(frame_sync), .nib_out(nib_out),
    .nib_valid(nib_valid), .nib_ready(nib_ready), .bit_cnt(bit_cnt),
    .nib_total(nib_total)
  );

  serial_nibble_collector #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(m_bit_ready), .frame_sync(frame_sync), .nib_out(m_nib_out),
    .nib_valid(m_nib_valid), .nib_ready(nib_ready), .bit_cnt(m_bit_cnt),
    .nib_total(m_nib_total)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pbits.delete();
    exp_q.delete();
    exp_m_q.delete();
    last_l = 4'd0;
    last_m = 4'd0;
    mtotal = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out"}, nib_out, 4'b0000);
    check({tag, "_valid"}, nib_valid, 1'b0);
    check({tag, "_cnt"}, bit_cnt, 2'd0);
    check({tag, "_total"}, nib_total, 8'd0);
    check({tag, "_m_out"}, m_nib_out, 4'b0000);
    check({tag, "_m_valid"}, m_nib_valid, 1'b0);
  endtask

  // One clock: drive at the falling edge, check bit_ready, advance the model,
  // then check the registered outputs just after the rising edge.
  task automatic cycle(input bit v, input bit b, input bit fs, input bit r);
    bit         exp_rdy, acc, hs;
    logic [3:0] wl, wm;
    @(negedge clk);
    bit_valid = v; bit_in = b; frame_sync = fs; nib_ready = r;
    #1;
    exp_rdy = !(pbits.size() == 3 && exp_q.size() != 0 && !r);
    obs_ready = bit_ready;
    check("bit_ready", bit_ready, exp_rdy);
    check("m_bit_ready", m_bit_ready, exp_rdy);
    acc = v && exp_rdy;
    hs  = (exp_q.size() != 0) && r;
    if (hs) begin
      void'(exp_q.pop_front());
      void'(exp_m_q.pop_front());
      mtotal = (mtotal + 1) % 256;
    end
    if (fs) pbits.delete();
    if (acc) pbits.push_back(b);
    if (pbits.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        wl[i]     = pbits[i];
        wm[3 - i] = pbits[i];
      end
      exp_q.push_back(wl);
      exp_m_q.push_back(wm);
      last_l = wl;
      last_m = wm;
      pbits.delete();
    end
    @(posedge clk);
    #1;
    check("nib_valid", nib_valid, exp_q.size() != 0);
    check("m_nib_valid", m_nib_valid, exp_m_q.size() != 0);
    check("nib_out", nib_out, last_l);
    check("m_nib_out", m_nib_out, last_m);
    check("bit_cnt", bit_cnt, pbits.size());
    check("m_bit_cnt", m_bit_cnt, pbits.size());
    check("nib_total", nib_total, mtotal);
    check("m_nib_total", m_nib_total, mtotal);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b0; frame_sync = 1'b0; nib_ready = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    check_reset_values("reset");
    check("reset_ready", bit_ready, 1'b1);
  endtask

  initial begin
    logic [3:0] seq_a;
    logic [3:0] seq_b;
    model_clear();

    // Reset then idle
    do_reset(2);

    // LSB-first, ready tied high: 0,1,0,1 then 1,0,1,1
    seq_a = 4'b1010;
    seq_b = 4'b1101;
    for (int i = 0; i < 4; i++) cycle(1'b1, seq_a[i], 1'b0, 1'b1);
    check("lsb_word0", nib_out, 4'b1010);
    check("lsb_word0_valid", nib_valid, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, seq_b[i], 1'b0, 1'b1);
    check("lsb_word1", nib_out, 4'b1101);
    check("msb_word1", m_nib_out, 4'b1011);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("lsb_total2", nib_total, 8'd2);
    check("lsb_idle_valid", nib_valid, 1'b0);

    // Back-pressure: 1111 held, three more bits, fourth stalls, then no bubble
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_held", nib_out, 4'b1111);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("bp_still_held", nib_out, 4'b1111);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_stall_ready", obs_ready, 1'b0);
    check("bp_stall_cnt", bit_cnt, 2'd3);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("bp_release_ready", obs_ready, 1'b1);
    check("bp_new_word", nib_out, 4'b1010);
    check("bp_no_bubble", nib_valid, 1'b1);
    check("bp_total", nib_total, 8'd3);

    // frame_sync mid-word with 1010 still pending
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("fs_cnt", bit_cnt, 2'd1);
    check("fs_held", nib_out, 4'b1010);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("fs_held_valid", nib_valid, 1'b1);
    check("fs_total", nib_total, 8'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("fs_word", nib_out, 4'b0000);

    // MSB-first instance: 1,1,0,1
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("msb_word", m_nib_out, 4'b1101);
    check("msb_lsb_word", nib_out, 4'b1011);

    // Completion and resync in the same cycle: resync wins
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("fs_override_valid", nib_valid, 1'b0);
    check("fs_override_cnt", bit_cnt, 2'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Wrap: 256 deliveries from reset brings nib_total back to 0
    do_reset(1);
    for (int i = 0; i < 1024; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_total", nib_total, 8'd0);

    // Reset mid-operation with bit_cnt = 2 and a word pending
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset_cnt", bit_cnt, 2'd2);
    check("pre_reset_valid", nib_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b1; nib_ready = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    check("midreset_ready", bit_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0; bit_valid = 1'b0;
    model_clear();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_nibble_collector.md
Name: serial_nibble_collector

Overview:
- Upstream feeder for the 4-bit combinational reduction stage.
- Assembles a serial bit stream into WIDTH-bit words and holds each completed word in an output register.
- Presents each held word to the reduction stage over a valid/ready handshake.
- Supports frame resynchronisation and keeps a wrapping count of delivered words for debug.

Parameters:
- WIDTH, 4, number of bits per assembled word; legal range is 2 and up.
- MSB_FIRST, 0, bit placement order.
  - 0: the first serial bit lands in bit 0.
  - 1: the first serial bit lands in bit WIDTH-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  collector can accept a bit this cycle; combinational.
- frame_sync  in  1  discard any partial word and restart assembly at bit position 0.
- nib_out  out  WIDTH  assembled word; registered.
- nib_valid  out  1  nib_out holds an undelivered word.
- nib_ready  in  1  downstream stage accepts nib_out.
- bit_cnt  out  CNT_W  bits collected toward the current word; CNT_W = clog2(WIDTH).
- nib_total  out  8  count of delivered words (handshakes completed), wraps 255 -> 0.

Behaviour:
- Reset (synchronous, takes priority over everything): shift register = 0, bit_cnt = 0, nib_out = 0, nib_valid = 0, nib_total = 0. bit_ready reads 1 in the first cycle after reset.
- A bit is accepted when bit_valid && bit_ready. It is written into the shift register at position bit_cnt (LSB-first), or at WIDTH-1-bit_cnt (MSB_FIRST=1).
- Partial words are never visible on nib_out.
- Word completion: a bit accepted while bit_cnt == WIDTH-1 completes the word.
  - Next edge: nib_out = complete word (including that bit), nib_valid = 1, bit_cnt = 0.
  - Latency from last bit accepted to nib_valid is 1 cycle.
- Hold-register FSM:
  - EMPTY (nib_valid = 0): a completion moves to FULL.
  - FULL: nib_valid && nib_ready with no completion moves to EMPTY.
  - FULL: a handshake and a completion in the same cycle stays FULL with the new word loaded (back-to-back, no bubble).
- bit_ready = NOT (bit_cnt == WIDTH-1 && nib_valid && !nib_ready).
  - Bits 0..WIDTH-2 are always accepted, even while the hold register is FULL.
  - Only the completing bit can stall.
- While nib_valid && !nib_ready, nib_out and nib_valid are held stable.
- A bit offered with bit_valid = 0 is ignored.
- frame_sync forces bit_cnt to 0 and discards the partial word.
  - If bit_valid is also high in the same cycle, that bit is accepted as bit 0 of the new word.
  - frame_sync never disturbs nib_out, nib_valid or nib_total.
  - frame_sync overrides a completion in the same cycle: no word is produced and the bit starts the new word.
- nib_total increments by 1 on each nib_valid && nib_ready cycle and wraps from 255 to 0.
- nib_out is driven only from registers, so the downstream reduction stage sees glitch-free inputs.

Decomposition:
- Shared package serial_pkg:
  - DEFAULT_WIDTH = 4.
  - A cnt_width(WIDTH) function returning clog2(WIDTH).
  - Hold-state encoding: EMPTY = 1'b0, FULL = 1'b1.
- One natural sub-module, bit_shifter: the parameterised shift register plus bit counter. Its ports are the accept strobe, bit, frame_sync and MSB_FIRST, and it outputs word and done.
- The top level owns the hold FSM, the handshake and nib_total.

Test Plan:
- Reset then idle: assert reset 2 cycles, release -> nib_out = 0000, nib_valid = 0, bit_cnt = 0, nib_total = 0, bit_ready = 1.
- LSB-first stream, nib_ready tied to 1: send bits 0,1,0,1 then 1,0,1,1.
  - nib_out = 1010, then 1101, each with nib_valid pulsing 1 cycle after the 4th bit.
  - nib_total = 2.
- Back-pressure, nib_ready = 0: send 1,1,1,1 -> nib_out = 1111 held.
  - Next 3 bits are accepted; 4th bit sees bit_ready = 0.
  - Raise nib_ready -> 1111 delivered, 4th bit accepted the same cycle.
  - New word loaded with no bubble.
- frame_sync mid-word: send 1,1, then frame_sync with bit 0, then 0,0,0.
  - nib_out = 0000; the partial 11 is discarded.
  - A held word that was pending stays unchanged.
- MSB_FIRST = 1 instance: send 1,1,0,1 -> nib_out = 1101.
- Wrap and reset mid-operation:
  - Deliver 256 words -> nib_total = 0.
  - Assert reset with bit_cnt = 2 and nib_valid = 1 -> all outputs return to their reset values on the next edge.
